// File: rtl/lsu_dmem_port.sv
// lsu_dmem_port: load/store front-end for one port of the dual-port data memory.
// Takes one request per handshake, drives registered enable/address/mask/data
// for a single cycle, waits MEM_LAT cycles for load data, then returns one
// aligned and extended response pulse.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned H/W accesses
// instead of silently aligning them down).
module lsu_dmem_port #(
    parameter int AW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_cen,
    output logic [3:0]    mem_wmask,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   cnt_reg;
    logic            we_reg;
    logic [2:0]      funct3_reg;
    logic [1:0]      lane_reg;
    logic            mis_reg;

    logic            accept;
    logic            mis_now;
    logic [3:0]      wmask_now;
    logic [31:0]     wdata_now;
    logic            last_wait;
    logic            store_done;
    logic [31:0]     load_data;

    logic            resp_valid_reg;
    logic [31:0]     resp_rdata_reg;
    logic            resp_err_reg;
    logic            mem_cen_reg;
    logic [3:0]      mem_wmask_reg;
    logic [AW-1:0]   mem_addr_reg;
    logic [31:0]     mem_wdata_reg;

    assign accept     = req_valid & req_ready;
    assign last_wait  = (state_reg == S_WAIT) && (cnt_reg == CW'(MEM_LAT - 1));
    // Stores and trapped accesses both answer straight out of ISSUE.
    assign store_done = (state_reg == S_ISSUE) && (we_reg || mis_reg);

    // Misalignment detection for the incoming request (word = funct3[1] set).
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        mis_now = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  (req_funct3[1] && (req_addr[1:0] != 2'b00));
`else
        mis_now = 1'b0;
`endif
    end

    // Store lane placement: replicate data across lanes, select bytes by mask.
    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                wdata_now = {4{req_wdata[7:0]}};
                wmask_now = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                wdata_now = {2{req_wdata[15:0]}};
                wmask_now = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_now = req_wdata;
                wmask_now = 4'b1111;
            end
        endcase
    end

    // Load extraction: pick the addressed lane and sign- or zero-extend.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = mem_rdata[8*lane_reg +: 8];
        half_sel = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_reg[1:0])
            2'b00:   load_data = funct3_reg[2] ? {24'd0, byte_sel}
                                               : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = funct3_reg[2] ? {16'd0, half_sel}
                                               : {{16{half_sel[15]}}, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_ISSUE;
            S_ISSUE: state_next = (we_reg || mis_reg) ? S_IDLE : S_WAIT;
            S_WAIT:  if (last_wait) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: requests are only taken in IDLE.
    always_comb begin
        req_ready = (state_reg == S_IDLE);
    end

    // Request capture, memory port registers, wait counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= '0;
            we_reg         <= 1'b0;
            funct3_reg     <= 3'd0;
            lane_reg       <= 2'd0;
            mis_reg        <= 1'b0;
            mem_cen_reg    <= 1'b0;
            mem_wmask_reg  <= 4'd0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            // Enable and mask are high for exactly the ISSUE cycle.
            mem_cen_reg   <= accept & ~mis_now;
            mem_wmask_reg <= (accept & req_we & ~mis_now) ? wmask_now : 4'd0;
            if (accept) begin
                mem_addr_reg  <= {req_addr[AW-1:2], 2'b00};
                mem_wdata_reg <= wdata_now;
                we_reg        <= req_we;
                funct3_reg    <= req_funct3;
                lane_reg      <= req_addr[1:0];
                mis_reg       <= mis_now;
            end

            if (state_reg == S_ISSUE) begin
                cnt_reg <= '0;
            end else if (state_reg == S_WAIT) begin
                cnt_reg <= cnt_reg + CW'(1);
            end

            resp_valid_reg <= store_done | last_wait;
            resp_err_reg   <= store_done & mis_reg;
            if (store_done) begin
                resp_rdata_reg <= '0;
            end else if (last_wait) begin
                resp_rdata_reg <= load_data;
            end
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign mem_cen    = mem_cen_reg;
    assign mem_wmask  = mem_wmask_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// tb_lsu_dmem_port: randomized bench for lsu_dmem_port with a byte-level
// reference memory and a per-cycle compare process. Honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_dmem_port;

    localparam int AW      = 32;
    localparam int MEM_LAT = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_cen;
    logic [3:0]    mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    lsu_dmem_port #(.AW(AW), .MEM_LAT(MEM_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_cen    (mem_cen),
        .mem_wmask  (mem_wmask),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous data memory driven by the DUT (64 words, aliased on addr[7:2]).
    logic [31:0] dmem [64];
    logic [31:0] rd_pipe [MEM_LAT];
    logic        mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) dmem[i] <= '0;
        end else if (mem_cen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) dmem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_cen) rd_pipe[0] <= dmem[mem_addr[7:2]];
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // Reference model state.
    logic [7:0]  ref_mem [256];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        checking = 1'b0;
    logic        p_valid = 1'b0;
    int          p_acc, p_resp;
    logic        p_cen, p_store, p_err;
    logic [3:0]  p_wmask;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic [31:0] last_rdata = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    // Compare process: every cycle out of reset, outputs versus the pending transaction.
    always @(negedge clk) begin
        logic busy, iss, rv;
        if (checking && !reset) begin
            busy = p_valid && (cyc > p_acc) && (cyc < p_resp);
            iss  = p_valid && (cyc == p_acc + 1);
            rv   = p_valid && (cyc == p_resp);
            chk("req_ready", 32'(req_ready), 32'(!busy));
            chk("mem_cen", 32'(mem_cen), 32'(iss && p_cen));
            chk("mem_wmask", 32'(mem_wmask), (iss && p_cen) ? 32'(p_wmask) : 32'd0);
            if (iss && p_cen) chk("mem_addr", mem_addr, p_addr);
            if (iss && p_cen && p_store) chk("mem_wdata", mem_wdata, p_wdata);
            chk("resp_valid", 32'(resp_valid), 32'(rv));
            if (rv) begin
                chk("resp_rdata", resp_rdata, p_rdata);
                chk("resp_err", 32'(resp_err), 32'(p_err));
                last_rdata = p_rdata;
            end else begin
                chk("rdata_hold", resp_rdata, last_rdata);
            end
        end
    end

    // One transaction: present at current negedge, model on accept, return at response negedge.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
        int s, off, base;
        logic m;
        logic [31:0] v;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        s    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(a[1:0]) & ~(s - 1);
        base = int'(a[7:2]) * 4 + off;
        m    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        m = ((s == 2) && a[0]) || ((s == 4) && (a[1:0] != 2'b00));
`endif
        p_acc   = cyc - 1;
        p_store = we;
        p_cen   = !m;
        p_err   = m;
        p_addr  = {a[31:2], 2'b00};
        p_wmask = 4'd0;
        p_wdata = 32'd0;
        p_rdata = 32'd0;
        if (m || we) begin
            p_resp = p_acc + 2;
        end else begin
            p_resp = p_acc + 2 + MEM_LAT;
        end
        if (!m && we) begin
            for (int k = 0; k < s; k++) begin
                ref_mem[base + k] = d[8*k +: 8];
                p_wmask[off + k]  = 1'b1;
            end
            for (int i = 0; i < 4; i++) p_wdata[8*i +: 8] = d[8*(i % s) +: 8];
        end else if (!m) begin
            v = 32'd0;
            for (int k = 0; k < s; k++) v[8*k +: 8] = ref_mem[base + k];
            if (s < 4 && !f3[2] && v[8*s-1])
                for (int k = s; k < 4; k++) v[8*k +: 8] = 8'hFF;
            p_rdata = v;
        end
        p_valid = 1'b1;
        $display("txn cyc=%0d we=%0d f3=%0d addr=%08h wdata=%08h exp_rdata=%08h exp_err=%0d",
                 p_acc, we, f3, a, d, p_rdata, m);
        repeat (p_resp - cyc) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic txn_lit(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] lit, input logic lit_err);
        txn(we, f3, a, d);
        chk("lit_rdata", resp_rdata, lit);
        chk("lit_err", 32'(resp_err), 32'(lit_err));
    endtask

    initial begin
        reset      = 1'b1;
        mem_clr    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        mem_clr  = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_cen", 32'(mem_cen), 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // Directed sequence with hand-computed results.
        txn_lit(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        txn_lit(1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'hFFFF_FFDE, 1'b0);
        txn_lit(1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h0000_00DE, 1'b0);
        txn_lit(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0000_0000, 1'b0);
        txn_lit(1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h1234_BEEF, 1'b0);
        txn_lit(1'b1, 3'b000, 32'h0000_0101, 32'h0000_0055, 32'h0000_0000, 1'b0);
        txn_lit(1'b0, 3'b101, 32'h0000_0100, 32'h0,         32'h0000_55EF, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        txn_lit(1'b0, 3'b010, 32'h0000_0102, 32'h0,         32'h0000_0000, 1'b1);
        txn_lit(1'b1, 3'b001, 32'h0000_0101, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
`else
        txn_lit(1'b0, 3'b010, 32'h0000_0102, 32'h0,         32'h1234_55EF, 1'b0);
`endif

        // Reset while a load sits in WAIT: the response must be dropped.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        p_acc     = cyc - 1;
        p_resp    = p_acc + 2 + MEM_LAT;
        p_cen     = 1'b1;
        p_store   = 1'b0;
        p_err     = 1'b0;
        p_addr    = 32'h0000_0100;
        p_wmask   = 4'd0;
        p_rdata   = 32'h1234_55EF;
        p_valid   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        p_valid    = 1'b0;
        last_rdata = 32'd0;
        @(negedge clk);
        chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_rst_mem_cen", 32'(mem_cen), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        txn_lit(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h1234_55EF, 1'b0);

        // Randomized traffic, mixing back-to-back and spaced requests.
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
